md_issue_ctrl: RTL
==================

Name: md_issue_ctrl

Overview:
Initiator-side front end for the multiply/divide unit in the E stage of the pipelined MIPS core. Decodes the E-stage mult/div class operation, issues a one-cycle start with registered operands to the multiply/divide unit, and generates the E-stage stall while that unit is occupied. Returns HI/LO for mfhi/mflo. Runs a latency watchdog that flags a unit that never drops busy.

Parameters:
MULT_LAT, 5, expected busy cycles for mult/multu
DIV_LAT, 10, expected busy cycles for div/divu
WD_SLACK, 4, extra cycles tolerated beyond expected latency before md_err

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
e_valid  in  1  E-stage instruction valid
e_md_op  in  4  E-stage md opcode (md_pkg encoding)
e_rs  in  32  forwarded rs value
e_rt  in  32  forwarded rt value
flush  in  1  exception flush; E-stage instruction is discarded
mlu_busy  in  1  busy from multiply/divide unit
mlu_hi  in  32  HI from multiply/divide unit
mlu_lo  in  32  LO from multiply/divide unit
mlu_start  out  1  registered one-cycle start
mlu_op  out  4  registered opcode to unit
mlu_d1  out  32  registered rs operand
mlu_d2  out  32  registered rt operand
stall_e  out  1  hold E stage and earlier
mf_data  out  32  mfhi/mflo result, valid when not stalled
md_err  out  1  sticky watchdog error
issue_cnt  out  16  number of ops issued, wraps at 0xFFFF->0

Behaviour:
- Reset: mlu_start=0, mlu_op=MD_NONE, mlu_d1=mlu_d2=0, md_err=0, issue_cnt=0, state=IDLE, wd counter=0.
- md_req = e_valid & !flush & e_md_op in {MULT..MFLO}. long = MULT/MULTU/DIV/DIVU. mt = MTHI/MTLO. mf = MFHI/MFLO.
- stall_e (combinational) = md_req & (state!=IDLE | mlu_busy). Non-md instructions never stall.
- States:
  - IDLE: if md_req & !stall_e & (long|mt), then at next edge mlu_start=1, mlu_op=e_md_op, mlu_d1=e_rs, mlu_d2=e_rt, issue_cnt+1. long goes to ISSUE. mt goes to MTW.
  - MTW: mlu_start=0, back to IDLE. Stall holds for this cycle, so the write lands before any following mf reads.
  - ISSUE: mlu_start=0, go to WAIT. Load wd counter with (DIV_LAT for div/divu else MULT_LAT) + WD_SLACK.
  - WAIT: stay while mlu_busy and decrement wd. When !mlu_busy go to IDLE. If wd reaches 0 while busy, set md_err=1 (sticky until reset) and stay in WAIT.
- mlu_start is high for exactly one cycle per issued op. There is never a back-to-back start.
- mf: mf_data = mlu_hi for MFHI, mlu_lo for MFLO, 0 otherwise. Combinational, and meaningful only when stall_e=0.
- MD_NONE and undefined codes 9–15 are treated as non-md: no stall, no issue.
- flush same cycle as an IDLE md_req: no issue, no stall.
- flush during ISSUE/WAIT: the in-flight op completes and is not cancelled; stall_e=0 that cycle because md_req=0.
- reset mid-operation returns to IDLE immediately and does not wait for mlu_busy.
- Operands are sampled only at the issue edge. Later e_rs/e_rt changes have no effect.

Decomposition:
- md_pkg: 4-bit opcode constants MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. It is shared with the multiply/divide unit and the decoder, together with the state encoding IDLE/ISSUE/MTW/WAIT.
- One combinational sub-module, md_class_decode: e_md_op -> is_long, is_mt, is_mf, lat_sel.

Test Plan:
- mult with rs=0xFFFFFFFF, rt=2, mlu_busy modelled 5 cycles -> one start pulse with op=MULT, d1=0xFFFFFFFF, d2=2. A following mflo stalls until busy drops, then mf_data=mlu_lo. issue_cnt=1.
- div issued, then mthi the next cycle -> mthi stalls through ISSUE and all WAIT cycles. Its start issues only after busy=0. Exactly two start pulses total.
- mthi rs=0x1234 then immediate mfhi -> mfhi stalls 1 cycle (MTW), then mf_data=0x1234 from a model HI.
- flush asserted with a divu in E while IDLE -> no mlu_start, stall_e=0, issue_cnt unchanged.
- mult issued, model holds busy high forever -> md_err=1 exactly MULT_LAT+WD_SLACK=9 cycles after entering WAIT. Remains 1 until reset.
- reset pulse during WAIT -> next cycle state IDLE, stall_e=0 for a pending mflo, all outputs at reset values.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit, its decoder and its issue front end.
// No logic: constants and types only.
// No flow control.
package md_pkg;

    // Multiply/divide opcodes; codes 9..15 are undefined and behave as non-md.
    localparam logic [3:0] MD_NONE = 4'd0;
    localparam logic [3:0] MULT    = 4'd1;
    localparam logic [3:0] MULTU   = 4'd2;
    localparam logic [3:0] DIV     = 4'd3;
    localparam logic [3:0] DIVU    = 4'd4;
    localparam logic [3:0] MTHI    = 4'd5;
    localparam logic [3:0] MTLO    = 4'd6;
    localparam logic [3:0] MFHI    = 4'd7;
    localparam logic [3:0] MFLO    = 4'd8;

    // Issue controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        MTW   = 2'd2,
        WAIT  = 2'd3
    } md_state_t;

endpackage

// File: rtl/md_class_decode.sv
// Classifies an md opcode into long (mult/div), move-to, move-from and latency class.
// Purely combinational, zero latency.
// No flow control.
module md_class_decode
    import md_pkg::*;
(
    input  logic [3:0] i_op,
    output logic       o_is_long,
    output logic       o_is_mt,
    output logic       o_is_mf,
    output logic       o_lat_sel
);

    // Opcode class lookup; o_lat_sel=1 selects the divide latency.
    always_comb begin
        o_is_long = 1'b0;
        o_is_mt   = 1'b0;
        o_is_mf   = 1'b0;
        o_lat_sel = 1'b0;
        case (i_op)
            MULT, MULTU: o_is_long = 1'b1;
            DIV, DIVU: begin
                o_is_long = 1'b1;
                o_lat_sel = 1'b1;
            end
            MTHI, MTLO:  o_is_mt = 1'b1;
            MFHI, MFLO:  o_is_mf = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// E-stage issue front end for the multiply/divide unit: start pulse, stall, HI/LO read, watchdog.
// Start and operands are registered (one cycle after the issuing E cycle); stall and mf_data are combinational.
// E stage is stalled while an md op is in flight or the unit is busy; in-flight ops are never cancelled.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int WD_SLACK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        flush,
    input  logic        mlu_busy,
    input  logic [31:0] mlu_hi,
    input  logic [31:0] mlu_lo,
    output logic        mlu_start,
    output logic [3:0]  mlu_op,
    output logic [31:0] mlu_d1,
    output logic [31:0] mlu_d2,
    output logic        stall_e,
    output logic [31:0] mf_data,
    output logic        md_err,
    output logic [15:0] issue_cnt
);

    localparam int WD_W = 8;
    localparam logic [WD_W-1:0] WD_MULT = WD_W'(MULT_LAT + WD_SLACK);
    localparam logic [WD_W-1:0] WD_DIV  = WD_W'(DIV_LAT + WD_SLACK);

    md_state_t       r_state;
    md_state_t       w_state_next;
    logic            r_start;
    logic [3:0]      r_op;
    logic [31:0]     r_d1;
    logic [31:0]     r_d2;
    logic            r_lat_div;
    logic [WD_W-1:0] r_wd;
    logic            r_err;
    logic [15:0]     r_cnt;

    logic            w_is_long;
    logic            w_is_mt;
    logic            w_is_mf;
    logic            w_lat_sel;
    logic            w_md_req;
    logic            w_stall;
    logic            w_issue;

    md_class_decode u_dec (
        .i_op      (e_md_op),
        .o_is_long (w_is_long),
        .o_is_mt   (w_is_mt),
        .o_is_mf   (w_is_mf),
        .o_lat_sel (w_lat_sel)
    );

    assign w_md_req = e_valid & ~flush & (w_is_long | w_is_mt | w_is_mf);
    assign w_stall  = w_md_req & ((r_state != IDLE) | mlu_busy);
    // mf ops never issue; they only read HI/LO once nothing is in flight.
    assign w_issue  = (r_state == IDLE) & w_md_req & ~w_stall & (w_is_long | w_is_mt);

    // Next-state: long ops wait out the unit, move-to ops take one settle cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_state_next = w_is_long ? ISSUE : MTW;
                end
            end
            MTW:   w_state_next = IDLE;
            ISSUE: w_state_next = WAIT;
            WAIT: begin
                if (!mlu_busy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight op without waiting for busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Issue registers: start is a single pulse, opcode/operands hold until the next issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start   <= 1'b0;
            r_op      <= MD_NONE;
            r_d1      <= '0;
            r_d2      <= '0;
            r_lat_div <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_start <= w_issue;
            if (w_issue) begin
                r_op      <= e_md_op;
                r_d1      <= e_rs;
                r_d2      <= e_rt;
                r_lat_div <= w_lat_sel;
                r_cnt     <= r_cnt + 16'd1;
            end
        end
    end

    // Watchdog: armed in ISSUE, counts busy cycles in WAIT, flags a sticky error on expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ISSUE) begin
                r_wd <= r_lat_div ? WD_DIV : WD_MULT;
            end else if ((r_state == WAIT) && mlu_busy && (r_wd != '0)) begin
                r_wd <= r_wd - 1'b1;
            end
            if ((r_state == WAIT) && mlu_busy && (r_wd <= WD_W'(1))) begin
                r_err <= 1'b1;
            end
        end
    end

    // Move-from result straight from the unit's HI/LO.
    always_comb begin
        mf_data = '0;
        case (e_md_op)
            MFHI:    mf_data = mlu_hi;
            MFLO:    mf_data = mlu_lo;
            default: mf_data = '0;
        endcase
    end

    assign mlu_start = r_start;
    assign mlu_op    = r_op;
    assign mlu_d1    = r_d1;
    assign mlu_d2    = r_d2;
    assign stall_e   = w_stall;
    assign md_err    = r_err;
    assign issue_cnt = r_cnt;

endmodule
